full_adder_signed_16bit: RTL and testbench
==========================================

// Module: full_adder_signed_16bit
// PURPOSE
//   16-bit two's-complement adder for the ALU datapath: S = A + B + Cin.
//   Built as a ripple chain of 1-bit full-adder cells (sum = a^b^c, carry = ab|ac|bc).
//   Outputs are registered, so results appear one cycle after the operands.
//   Flags: unsigned carry-out (Cout) and signed overflow (Ovf).
// PARAMETERS
//   WIDTH  16  operand/result width in bits; all behaviour below is written for WIDTH=16
// PORTS
//   clk   in   1      clock; all state updates on its rising edge
//   rst   in   1      asynchronous, active-high reset
//   A     in   16     operand A, two's complement
//   B     in   16     operand B, two's complement
//   Cin   in   1      carry-in to bit 0
//   S     out  16     registered sum, bits [15:0] of A+B+Cin
//   Cout  out  1      registered carry out of bit 15
//   Ovf   out  1      registered signed overflow
//   Interface: one clock; reset is asynchronous and active-high.
// BEHAVIOUR
//   - Reset: while rst=1, S=16'h0000, Cout=0 and Ovf=0 immediately, independent of clk.
//   - Reset deassertion: the first result is the one captured at the first rising clk edge with rst=0.
//   - Datapath: combinational ripple of WIDTH full-adder cells.
//     - c[0] = Cin.
//     - s[i] = A[i]^B[i]^c[i].
//     - c[i+1] = A[i]&B[i] | A[i]&c[i] | B[i]&c[i].
//   - Flags:
//     - Cout = c[16].
//     - Ovf = c[16]^c[15], equivalently (A[15]==B[15]) && (s[15]!=A[15]).
//   - Latency: on each rising clk edge with rst=0, the registers capture s, c[16] and the overflow term.
//     - Outputs therefore reflect the operands present at the previous edge.
//     - Throughput is one result per cycle; there is no handshake, and every cycle is valid.
//   - Width rules:
//     - The result is always truncated to 16 bits and wraps modulo 2^16.
//     - There is no saturation, and S is never sign-extended or clamped on overflow.
//   - Boundary cases:
//     - 16'h7FFF+1 wraps to 16'h8000 with Ovf=1.
//     - 16'hFFFF+1 wraps to 16'h0000 with Cout=1 and Ovf=0.
//     - Negative plus negative giving a positive result sets both Cout and Ovf.
//   - Reset mid-operation clears the outputs at once; an in-flight result is discarded.
//   - No X propagation from the reset state: all three output registers have defined reset values.
// TESTING (Cin=0 unless stated; check outputs one cycle after applying operands)
//   - rst=1, then release; A=0000 B=0000 -> S=0000 Cout=0 Ovf=0. During reset, outputs are 0 without a clk edge.
//   - A=0001 B=0001 -> S=0002 Cout=0 Ovf=0; A=0001 B=0001 Cin=1 -> S=0003.
//   - A=8030 B=80E0 -> S=0110 Cout=1 Ovf=1; A=8000 B=0400 -> S=8400 Cout=0 Ovf=0.
//   - A=4001 B=4003 -> S=8004 Cout=0 Ovf=1; A=7FFF B=0001 -> S=8000 Cout=0 Ovf=1.
//   - A=FFFF B=0001 -> S=0000 Cout=1 Ovf=0; A=FFFF B=FFFF -> S=FFFE Cout=1 Ovf=0.
//   - Back-to-back operands every cycle, with rst asserted asynchronously mid-stream:
//     - Each result matches its operands exactly one cycle later.
//     - Outputs go to 0 as soon as rst rises.
//     - Random sweep of 10k vectors compared against a 17-bit reference sum.

Source files
------------

// File: rtl/full_adder_signed_16bit.sv
// ---------------------------------------------------------------------------
// full_adder_signed_16bit
//
// Purpose:
//   Registered two's-complement adder for the ALU datapath, S = A + B + Cin.
//   The sum is formed by a ripple chain of 1-bit full-adder cells. The sum
//   and both flags are registered, so a result appears one clock after its
//   operands. A new result is produced every cycle and there is no handshake.
//
// Ports:
//   clk   in   1      clock, all state updates on the rising edge
//   rst   in   1      asynchronous, active-high reset (clears all outputs)
//   A     in   WIDTH  operand A, two's complement
//   B     in   WIDTH  operand B, two's complement
//   Cin   in   1      carry into bit 0
//   S     out  WIDTH  registered sum, wraps modulo 2^WIDTH
//   Cout  out  1      registered carry out of the top bit (unsigned carry)
//   Ovf   out  1      registered signed overflow
// ---------------------------------------------------------------------------
module full_adder_signed_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  // Carry chain: carry[i] is the carry into bit i, and carry[WIDTH] leaves the top bit.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Ripple of full-adder cells. The loop is kept inside a single process so
  // that each cell's carry feeds the next cell directly.
  always_comb begin
    carry    = '0;
    sum_d    = '0;
    carry[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = A[i] ^ B[i] ^ carry[i];
      carry[i+1] = (A[i] & B[i]) | (A[i] & carry[i]) | (B[i] & carry[i]);
    end
  end

  // Signed overflow happens when the carry into the sign bit differs from
  // the carry out of it. This is the same as two operands with equal signs
  // producing a sum whose sign differs from theirs.
  always_comb begin
    cout_d = carry[WIDTH];
    ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
  end

  // Output registers. Reset clears them at once, which discards any result
  // that is in flight, so no X ever reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign S    = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_full_adder_signed_16bit.sv
// ---------------------------------------------------------------------------
// tb_full_adder_signed_16bit
//
// Scoreboard bench for the registered 16-bit adder. Stimulus applies operands
// on the falling edge and queues the response it expects. A separate monitor
// pops one entry shortly after each rising edge and compares it with the DUT
// outputs. Directed vectors carry hand-written expectations. Random vectors
// are scored against a plain-arithmetic model that uses a 17-bit unsigned
// sum and a signed integer range check.
// ---------------------------------------------------------------------------
module tb_full_adder_signed_16bit;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } resT;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] S;
  logic        Cout;
  logic        Ovf;

  resT expQ[$];
  int  tests;
  int  failures;

  full_adder_signed_16bit #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .Ovf  (Ovf)
  );

  // Clock with period 10. Rising edges occur at 5, 15, 25 and so on.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It takes the unsigned 17-bit sum for S and Cout. It
  // flags overflow when the true signed sum falls outside the 16-bit range.
  function automatic resT refModel(input logic [15:0] a, input logic [15:0] b, input logic cin);
    resT         r;
    logic [16:0] u;
    int          sa;
    u   = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    sa  = int'($signed(a)) + int'($signed(b)) + int'(cin);
    r.s = u[15:0];
    r.c = u[16];
    r.o = (sa > 32767) || (sa < -32768);
    return r;
  endfunction

  // Compare the current outputs against one expected response and count it.
  task automatic checkOutput(input string name, input resT exp);
    tests++;
    if (S !== exp.s || Cout !== exp.c || Ovf !== exp.o) begin
      failures++;
      $display("[TB] FAIL %s: got S=%h Cout=%b Ovf=%b, expected S=%h Cout=%b Ovf=%b",
               name, S, Cout, Ovf, exp.s, exp.c, exp.o);
    end
  endtask

  // Drive one operand set on the falling edge and queue its expected response.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input resT exp);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    expQ.push_back(exp);
  endtask

  // Raise reset between clock edges while a result is still in flight. The
  // outputs must clear without waiting for a clock edge. Reset is then held
  // across one rising edge. On release, the operands still being driven
  // produce the first result.
  task automatic pulseReset();
    resT zero;
    zero = '{s: 16'h0000, c: 1'b0, o: 1'b0};
    #2;
    rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("async_reset_clear", zero);
    @(posedge clk);
    #1;
    checkOutput("reset_held_over_edge", zero);
    @(negedge clk);
    rst = 1'b0;
    expQ.push_back(refModel(A, B, Cin));
  endtask

  // Monitor. Every cycle carries a valid result, so after each rising edge
  // outside of reset it pops the oldest expectation and compares it.
  always @(posedge clk) begin
    #1;
    if (!rst && expQ.size() > 0) begin
      resT exp;
      exp = expQ.pop_front();
      checkOutput("scoreboard", exp);
    end
  end

  initial begin
    resT zero;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    tests    = 0;
    failures = 0;
    zero     = '{s: 16'h0000, c: 1'b0, o: 1'b0};
    rst      = 1'b0;
    A        = 16'h0000;
    B        = 16'h0000;
    Cin      = 1'b0;

    // Raise reset before any rising clock edge has occurred.
    #1;
    rst = 1'b1;
    #1;
    checkOutput("reset_no_clock", zero);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, each with its expected response.
    applyStimulus(16'h0000, 16'h0000, 1'b0, '{s: 16'h0000, c: 1'b0, o: 1'b0});
    applyStimulus(16'h0001, 16'h0001, 1'b0, '{s: 16'h0002, c: 1'b0, o: 1'b0});
    applyStimulus(16'h0001, 16'h0001, 1'b1, '{s: 16'h0003, c: 1'b0, o: 1'b0});
    applyStimulus(16'h8030, 16'h80E0, 1'b0, '{s: 16'h0110, c: 1'b1, o: 1'b1});
    applyStimulus(16'h8000, 16'h0400, 1'b0, '{s: 16'h8400, c: 1'b0, o: 1'b0});
    applyStimulus(16'h4001, 16'h4003, 1'b0, '{s: 16'h8004, c: 1'b0, o: 1'b1});
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, '{s: 16'h8000, c: 1'b0, o: 1'b1});
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, '{s: 16'h0000, c: 1'b1, o: 1'b0});
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, '{s: 16'hFFFE, c: 1'b1, o: 1'b0});
    applyStimulus(16'h7FFF, 16'h0000, 1'b1, '{s: 16'h8000, c: 1'b0, o: 1'b1});
    applyStimulus(16'h8000, 16'hFFFF, 1'b0, '{s: 16'h7FFF, c: 1'b1, o: 1'b1});
    applyStimulus(16'hFFFF, 16'h0000, 1'b1, '{s: 16'h0000, c: 1'b1, o: 1'b0});

    // Random back-to-back sweep, with reset pulsed part-way through.
    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, refModel(ra, rb, rc));
      if (n % 2500 == 1234) pulseReset();
    end

    // Drain the final result, then confirm nothing was left unchecked.
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  // Upper bound on run time in case the stimulus process stalls.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no completion by 500000, expected finish");
    failures++;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
